// File: rtl/stage_id_scoreboard.sv
// Decode-stage hazard scoreboard: tracks pending destinations of long-latency
// producers and raises the ID stall for RAW, WAW and outstanding-budget hazards.
module stage_id_scoreboard #(
  parameter int REG_NUM         = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WB_BYPASS       = 1,
  parameter int CNT_W           = 32,
  localparam int AW = $clog2(REG_NUM),
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic [AW-1:0]      id_rs1,
  input  logic [AW-1:0]      id_rs2,
  input  logic               id_writes_rd,
  input  logic [AW-1:0]      id_rd,
  input  logic               id_is_long,
  input  logic               issue_ready,
  input  logic               flush,
  input  logic               wb_valid,
  input  logic [AW-1:0]      wb_rd,
  output logic               stall,
  output logic               issue,
  output logic [REG_NUM-1:0] pending_mask,
  output logic [OW-1:0]      outstanding,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               wb_err
);

  localparam logic [OW-1:0]      MAX_OUT  = OW'(MAX_OUTSTANDING);
  localparam logic [REG_NUM-1:0] X0_CLEAR = {{(REG_NUM-1){1'b1}}, 1'b0};

  // Pending as seen by decode; a same-cycle writeback can hide the bit when bypassing.
  function automatic logic eff_pending(input logic [REG_NUM-1:0] pend,
                                       input logic [AW-1:0]      r,
                                       input logic               wbv,
                                       input logic [AW-1:0]      wbr);
    logic bypass_hit;
    bypass_hit = (WB_BYPASS != 0) && wbv && (wbr == r);
    return (r != '0) && pend[r] && !bypass_hit;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic wb_legal;
  logic wb_illegal;
  logic raw_hazard;
  logic waw_hazard;
  logic budget_hazard;
  logic set_en;
  logic [REG_NUM-1:0] set_vec;
  logic [REG_NUM-1:0] clr_vec;

  assign wb_legal   = wb_valid && (wb_rd != '0) && pending_mask[wb_rd];
  assign wb_illegal = wb_valid && !wb_legal;

  assign raw_hazard =
      (id_uses_rs1 && eff_pending(pending_mask, id_rs1, wb_valid, wb_rd)) ||
      (id_uses_rs2 && eff_pending(pending_mask, id_rs2, wb_valid, wb_rd));
  assign waw_hazard = id_writes_rd && eff_pending(pending_mask, id_rd, wb_valid, wb_rd);
  assign budget_hazard = id_is_long && id_writes_rd && (id_rd != '0) &&
                         (outstanding == MAX_OUT) && !wb_legal;

  assign stall  = id_valid && !flush && (raw_hazard || waw_hazard || budget_hazard);
  assign issue  = id_valid && !flush && !stall && issue_ready;
  assign set_en = issue && id_is_long && id_writes_rd && (id_rd != '0);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en)   set_vec[id_rd] = 1'b1;
    if (wb_legal) clr_vec[wb_rd] = 1'b1;
  end

  // Scoreboard state; a register set and cleared in the same cycle stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_mask <= '0;
      outstanding  <= '0;
      stall_cycles <= '0;
      wb_err       <= 1'b0;
    end else begin
      pending_mask <= ((pending_mask & ~clr_vec) | set_vec) & X0_CLEAR;
      case ({set_en, wb_legal})
        2'b10:   if (outstanding != MAX_OUT) outstanding <= outstanding + OW'(1);
        2'b01:   if (outstanding != '0)      outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
      if (wb_illegal) wb_err <= 1'b1;
      if (stall)      stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule
